// File: rtl/tff_counter_bank_if.sv
// Control/status bundle for tff_counter_bank: mode and load controls in,
// register state and status flags out.
interface tff_counter_bank_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] t;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, mode, t, load, load_val,
        input  q, tc, wrap
    );

    modport slave (
        input  en, mode, t, load, load_val,
        output q, tc, wrap
    );
endinterface

// File: rtl/tff_counter_bank.sv
// WIDTH-bit register of toggle cells acting either as a per-bit toggle bank
// or as a modulo-MOD up/down counter with optional saturation.
module tff_counter_bank #(
    parameter int WIDTH    = 8,
    parameter int MOD      = 256,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                rst_sync,
    tff_counter_bank_if.slave   bus
);
    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam logic [WIDTH:0]   MAX_C = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH-1:0] MAX_Q = MAX_C[WIDTH-1:0];

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] next_s;
    logic             wrap_next_s;
    logic [WIDTH-1:0] tog_s;
    logic [WIDTH:0]   q_ext_s;
    logic [WIDTH:0]   inc_s;
    logic [WIDTH:0]   dec_s;
    logic [WIDTH:0]   ld_ext_s;
    logic             tc_s;
    mode_e            mode_s;

    assign mode_s   = mode_e'(bus.mode);
    assign q_ext_s  = {1'b0, q_r};
    assign ld_ext_s = {1'b0, bus.load_val};
    // One extra bit keeps the carry out of q+1 and the borrow out of q-1 visible.
    assign inc_s    = q_ext_s + (WIDTH+1)'(1);
    assign dec_s    = q_ext_s - (WIDTH+1)'(1);

    // Next-state selection: load beats the mode operation, en gates the mode.
    always_comb begin
        next_s      = q_r;
        wrap_next_s = 1'b0;
        if (bus.load) begin
            if ((mode_s == MODE_UP) || (mode_s == MODE_DOWN)) begin
                next_s = (ld_ext_s > MAX_C) ? MAX_Q : bus.load_val;
            end else begin
                next_s = bus.load_val;
            end
        end else if (bus.en) begin
            case (mode_s)
                MODE_TOGGLE: begin
                    next_s = q_r ^ bus.t;
                end
                MODE_UP: begin
                    if (inc_s > MAX_C) begin
                        if (SATURATE != 0) begin
                            next_s = MAX_Q;
                        end else begin
                            next_s      = {WIDTH{1'b0}};
                            wrap_next_s = 1'b1;
                        end
                    end else begin
                        next_s = inc_s[WIDTH-1:0];
                    end
                end
                MODE_DOWN: begin
                    // Borrow out of the extended subtract means q was zero.
                    if (dec_s[WIDTH]) begin
                        if (SATURATE != 0) begin
                            next_s = {WIDTH{1'b0}};
                        end else begin
                            next_s      = MAX_Q;
                            wrap_next_s = 1'b1;
                        end
                    end else if (q_ext_s > MAX_C) begin
                        next_s = MAX_Q;
                    end else begin
                        next_s = dec_s[WIDTH-1:0];
                    end
                end
                MODE_HOLD: begin
                    next_s = q_r;
                end
                default: begin
                    next_s = q_r;
                end
            endcase
        end else begin
            next_s = q_r;
        end
    end

    // Each cell toggles exactly where the next value differs from the current one.
    assign tog_s = q_r ^ next_s;

    // Toggle-cell register and wrap pulse, synchronous reset has top priority.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            q_r    <= {WIDTH{1'b0}};
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_r ^ tog_s;
            wrap_r <= wrap_next_s;
        end
    end

    // Terminal count looks at the current mode, not at en.
    always_comb begin
        tc_s = 1'b0;
        case (mode_s)
            MODE_UP:   tc_s = (q_ext_s == MAX_C);
            MODE_DOWN: tc_s = (q_r == {WIDTH{1'b0}});
            default:   tc_s = 1'b0;
        endcase
    end

    assign bus.q    = q_r;
    assign bus.wrap = wrap_r;
    assign bus.tc   = tc_s;
endmodule
